// File: rtl/uart_imem_loader_pkg.sv
// Shared types and framing constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        CHECK,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// MSB-first 8-to-32 assembler; emits a one-cycle word_valid the cycle after the 4th byte.
module imem_word_assembler
    import uart_imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shreg;
    logic [1:0]  bcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg      <= '0;
            bcnt       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                shreg <= '0;
                bcnt  <= '0;
            end else if (byte_valid) begin
                // Word is copied out on the last byte, so the next byte may shift in freely.
                if (bcnt == 2'(BYTES_PER_WORD - 1)) begin
                    word       <= {shreg, byte_in};
                    word_valid <= 1'b1;
                end
                shreg <= {shreg[15:0], byte_in};
                bcnt  <= bcnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a length-prefixed UART program image into instruction RAM, holding the CPU meanwhile.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          TIMEOUT    = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [15:0]   n, wcnt;
    logic [TW-1:0] tcnt;
    logic          len_bad, last_wr, tmo, in_data;

    assign in_data   = (state == DATA);
    assign len_bad   = (n == 16'd0) || ({1'b0, n} > (17'd1 << ADDR_WIDTH));
    assign last_wr   = wr_en && (wcnt == n - 16'd1);
    assign tmo       = !rx_valid && (tcnt == TW'(TIMEOUT - 1));
    assign cpu_hold  = (state == LEN_LO) || (state == CHECK) || in_data;
    assign load_done = (state == DONE);

    // Outside DATA the assembler is held clear, so partial words never survive.
    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (!in_data),
        .byte_valid (rx_valid && in_data),
        .byte_in    (rx_data),
        .word       (wr_data),
        .word_valid (wr_en)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_valid) state_nx = LEN_LO;
            LEN_LO:  if (rx_valid) state_nx = CHECK;
                     else if (tmo) state_nx = ERR;
            CHECK:   state_nx = len_bad ? ERR : DATA;
            DATA:    if (last_wr)  state_nx = DONE;
                     else if (tmo) state_nx = ERR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            n        <= '0;
            wcnt     <= '0;
            tcnt     <= '0;
            wr_addr  <= BASE_ADDR;
            load_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && rx_valid) begin
                n[15:8]  <= rx_data;
                load_err <= 1'b0;
            end
            if (state == LEN_LO && rx_valid)
                n[7:0] <= rx_data;
            if ((state == LEN_LO || in_data) && !rx_valid)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (state == CHECK) begin
                wcnt    <= '0;
                wr_addr <= BASE_ADDR;
            end else if (wr_en) begin
                wcnt    <= wcnt + 16'd1;
                wr_addr <= wr_addr + 32'd4;
            end
            if (state_nx == ERR)
                load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench: stimulus pushes expected RAM writes; a negedge monitor pops and compares.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        cpu_hold, load_done, load_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];
    logic [7:0]  stim[$];

    uart_imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .TIMEOUT(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wr_en) begin
            last_addr = wr_addr;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", wr_addr, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e[63:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
        end
        if (load_done) begin
            done_cnt++;
            chk("hold_in_done", 32'(cpu_hold), 32'd0);
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic play(input int gap);
        while (stim.size() != 0) begin
            send(stim.pop_front());
            idle(gap);
        end
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        stim.push_back(d[31:24]);
        stim.push_back(d[23:16]);
        stim.push_back(d[15:8]);
        stim.push_back(d[7:0]);
    endtask

    initial begin
        int d0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(3);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", wr_addr, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_err), 0);
        reset = 1'b1;
        idle(2);

        // Two-word program
        send(8'h00);
        chk("t1_hold_first", 32'(cpu_hold), 1);
        chk("t1_err_first", 32'(load_err), 0);
        idle(2);
        stim.push_back(8'h02);
        push_word(32'h0, 32'h2009_0001);
        push_word(32'h4, 32'h23BD_FFFC);
        play(2);
        chk("t1_hold_mid", 32'(cpu_hold), 0);
        idle(5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_hold_end", 32'(cpu_hold), 0);
        chk("t1_err", 32'(load_err), 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // N=0 is rejected, then a valid frame clears the error
        stim = '{8'h00, 8'h00};
        play(2);
        idle(5);
        chk("t2_err", 32'(load_err), 1);
        chk("t2_hold", 32'(cpu_hold), 0);
        send(8'h00);
        chk("t2_err_clr", 32'(load_err), 0);
        idle(2);
        stim.push_back(8'h01);
        push_word(32'h0, 32'hDEAD_BEEF);
        play(2);
        idle(5);
        chk("t2_done_cnt", done_cnt, 2);
        chk("t2_q_empty", exp_q.size(), 0);

        // N=257 exceeds capacity; N=256 fills it exactly
        stim = '{8'h01, 8'h01};
        play(2);
        idle(5);
        chk("t3_err_257", 32'(load_err), 1);
        chk("t3_done_257", done_cnt, 2);
        stim = '{8'h01, 8'h00};
        play(2);
        for (int i = 0; i < 256; i++)
            push_word(32'(i * 4), {8'(i), ~8'(i), 8'h3C, 8'(i * 3)});
        play(1);
        idle(5);
        chk("t3_done_256", done_cnt, 3);
        chk("t3_last_addr", last_addr, 32'h3FC);
        chk("t3_err_256", 32'(load_err), 0);
        chk("t3_q_empty", exp_q.size(), 0);

        // Stall mid-word until the idle timeout fires
        stim = '{8'h00, 8'h01, 8'hAF, 8'hA9};
        play(2);
        idle(60);
        chk("t4_err", 32'(load_err), 1);
        chk("t4_hold", 32'(cpu_hold), 0);
        chk("t4_done", done_cnt, 3);

        // Reset after the first word of a 3-word frame
        stim = '{8'h00, 8'h03};
        push_word(32'h0, 32'h0102_0304);
        play(2);
        idle(2);
        send(8'h11);
        idle(2);
        send(8'h22);
        reset = 1'b0;
        idle(2);
        chk("t5_rst_addr", wr_addr, 32'h0);
        chk("t5_rst_hold", 32'(cpu_hold), 0);
        chk("t5_rst_err", 32'(load_err), 0);
        chk("t5_rst_wr_data", wr_data, 32'h0);
        reset = 1'b1;
        idle(20);
        chk("t5_q_empty", exp_q.size(), 0);
        stim = '{8'h00, 8'h01};
        push_word(32'h0, 32'hCAFE_BABE);
        play(2);
        idle(5);
        chk("t5_done", done_cnt, 4);
        chk("t5_q_empty2", exp_q.size(), 0);

        // Back-to-back frames, one byte every cycle: the CHECK-cycle byte (EE),
        // the byte alongside the final write (AB) and the DONE-cycle byte (FF) are dropped.
        d0 = done_cnt;
        stim = '{8'h00, 8'h01, 8'hEE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'hFF,
                 8'h00, 8'h01, 8'hEE, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAB, 8'hFF};
        exp_q.push_back({32'h0, 32'h1122_3344});
        exp_q.push_back({32'h0, 32'h5566_7788});
        play(0);
        idle(5);
        chk("t6_done", done_cnt - d0, 2);
        chk("t6_err", 32'(load_err), 0);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
